// File: rtl/seq_det_rr_sched.sv
// Shared pattern detector for NCH serial bit streams with a round-robin arbiter.
// Optional per-channel match counters are enabled by defining SEQ_DET_CNT_EN.
module seq_det_rr_sched #(
    parameter int                 NCH     = 4,
    parameter int                 PAT_LEN = 7,
    parameter logic [PAT_LEN-1:0] PATTERN = 7'b1010101,
    localparam int                CHW     = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [NCH-1:0] req,
    input  logic [NCH-1:0] din,
    input  logic [NCH-1:0] clr,
    output logic [NCH-1:0] gnt,
    output logic           match_vld,
    output logic [CHW-1:0] match_ch,
    input  logic [CHW-1:0] cnt_sel,
    output logic [7:0]     cnt_out
);

    localparam int FW = $clog2(PAT_LEN + 1);

    logic [CHW-1:0]     rr_ptr;
    logic [PAT_LEN-1:0] hist [NCH];
    logic [FW-1:0]      fill [NCH];

    logic [NCH-1:0]     elig;
    logic [CHW-1:0]     gnt_idx;
    logic               any_gnt;
    logic [PAT_LEN-1:0] new_hist;
    logic [FW-1:0]      new_fill;
    logic               match_nxt;

    // Reset gates eligibility so the grant drops the moment rst rises.
    assign elig = req & ~clr & {NCH{~rst}};

    // NOTE: every variable gets a default at the top of always_comb; a path
    // that leaves one unassigned would infer a latch.
    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        any_gnt = 1'b0;
        for (int i = 0; i < NCH; i++) begin
            if (!any_gnt && elig[(int'(rr_ptr) + i) % NCH]) begin
                gnt[(int'(rr_ptr) + i) % NCH] = 1'b1;
                gnt_idx = CHW'((int'(rr_ptr) + i) % NCH);
                any_gnt = 1'b1;
            end
        end
    end

    always_comb begin
        new_hist  = {hist[gnt_idx][PAT_LEN-2:0], din[gnt_idx]};
        new_fill  = (fill[gnt_idx] == FW'(PAT_LEN)) ? fill[gnt_idx] : fill[gnt_idx] + 1'b1;
        match_nxt = any_gnt && (new_hist == PATTERN) && (new_fill == FW'(PAT_LEN));
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    // NOTE: the history arrays are small flop banks, not RAM, so they take
    // the async reset like any other state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_ptr    <= '0;
            match_vld <= 1'b0;
            match_ch  <= '0;
            for (int j = 0; j < NCH; j++) begin
                hist[j] <= '0;
                fill[j] <= '0;
            end
        end else begin
            match_vld <= match_nxt;
            if (any_gnt) begin
                rr_ptr   <= (gnt_idx == CHW'(NCH - 1)) ? '0 : gnt_idx + 1'b1;
                match_ch <= gnt_idx;
            end
            for (int j = 0; j < NCH; j++) begin
                if (clr[j]) begin
                    hist[j] <= '0;
                    fill[j] <= '0;
                end else if (gnt[j]) begin
                    hist[j] <= new_hist;
                    fill[j] <= new_fill;
                end
            end
        end
    end

`ifdef SEQ_DET_CNT_EN
    logic [7:0] cnt [NCH];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int j = 0; j < NCH; j++) cnt[j] <= '0;
        end else begin
            for (int j = 0; j < NCH; j++) begin
                if (clr[j])
                    cnt[j] <= '0;
                else if (match_nxt && gnt[j] && cnt[j] != 8'hFF)
                    cnt[j] <= cnt[j] + 8'd1;
            end
        end
    end

    assign cnt_out = (int'(cnt_sel) < NCH) ? cnt[cnt_sel] : 8'h00;
`else
    logic unused_cnt_sel;
    assign unused_cnt_sel = ^cnt_sel;
    assign cnt_out        = 8'h00;
`endif

endmodule

// File: tb/tb_seq_det_rr_sched.sv
// Directed bench for seq_det_rr_sched (NCH=4, PAT_LEN=7, PATTERN=1010101).
module tb_seq_det_rr_sched;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [3:0] req = '0;
    logic [3:0] din = '0;
    logic [3:0] clr = '0;
    logic [3:0] gnt;
    logic       match_vld;
    logic [1:0] match_ch;
    logic [1:0] cnt_sel = '0;
    logic [7:0] cnt_out;

    int passed = 0;
    int total  = 0;

    seq_det_rr_sched dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .din       (din),
        .clr       (clr),
        .gnt       (gnt),
        .match_vld (match_vld),
        .match_ch  (match_ch),
        .cnt_sel   (cnt_sel),
        .cnt_out   (cnt_out)
    );

    always #5 clk = ~clk;

    // Pattern bit i (0 = oldest) of 1010101.
    function automatic logic pat_bit(input int i);
        return (i % 2) == 0;
    endfunction

    task automatic do_reset();
        @(negedge clk);
        req = '0; din = '0; clr = '0;
        rst = 1'b1;
        #1;
        total++;
        if (gnt !== 4'b0000 || match_vld !== 1'b0 || match_ch !== 2'd0)
            $display("FAIL reset_state: gnt=%b match_vld=%b match_ch=%0d, want 0000/0/0",
                     gnt, match_vld, match_ch);
        else passed++;
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Sole requester sends one bit; grant is checked before the edge, match after.
    task automatic send(input int ch, input logic b, input logic exp_m, input string name);
        @(negedge clk);
        req = '0; req[ch] = 1'b1; din[ch] = b;
        #1;
        total++;
        if (gnt !== (4'b0001 << ch))
            $display("FAIL %s_gnt: gnt=%b want=%b", name, gnt, 4'b0001 << ch);
        else passed++;
        @(posedge clk); #1;
        total++;
        if (match_vld !== exp_m || (exp_m && match_ch !== 2'(ch)))
            $display("FAIL %s_match: match_vld=%b match_ch=%0d want %b/%0d",
                     name, match_vld, match_ch, exp_m, ch);
        else passed++;
    endtask

    task automatic idle_check(input string name);
        @(negedge clk);
        req = '0;
        @(posedge clk); #1;
        total++;
        if (match_vld !== 1'b0)
            $display("FAIL %s_idle: match_vld=%b want 0", name, match_vld);
        else passed++;
    endtask

    task automatic test_reset();
        do_reset();
    endtask

    task automatic test_single();
        do_reset();
        for (int i = 0; i < 7; i++) send(0, pat_bit(i), i == 6, "single");
        idle_check("single");
    endtask

    task automatic test_overlap();
        do_reset();
        for (int i = 0; i < 11; i++)
            send(1, pat_bit(i), (i == 6) || (i == 8) || (i == 10), "overlap");
        idle_check("overlap");
    endtask

    task automatic test_round_robin();
        logic [3:0] exp_gnt [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        do_reset();
        @(negedge clk);
        req = 4'b1111; din = '0;
        for (int c = 0; c < 5; c++) begin
            #1;
            total++;
            if (gnt !== exp_gnt[c])
                $display("FAIL rr_gnt%0d: gnt=%b want=%b", c, gnt, exp_gnt[c]);
            else passed++;
            @(posedge clk); #1;
            total++;
            if (match_vld !== 1'b0)
                $display("FAIL rr_match%0d: match_vld=%b want 0", c, match_vld);
            else passed++;
            @(negedge clk);
        end
        req = '0;
    endtask

    task automatic test_clear();
        do_reset();
        for (int i = 0; i < 6; i++) send(2, pat_bit(i), 1'b0, "clr_pre");
        @(negedge clk);
        req = 4'b0100; clr = 4'b0100; din[2] = 1'b1;
        #1;
        total++;
        if (gnt !== 4'b0000)
            $display("FAIL clr_gnt: gnt=%b want=0000", gnt);
        else passed++;
        @(posedge clk); #1;
        @(negedge clk);
        clr = '0;
        send(2, 1'b1, 1'b0, "clr_after");
        for (int i = 0; i < 7; i++) send(2, pat_bit(i), i == 6, "clr_fresh");
        idle_check("clr");
    endtask

    task automatic test_interleaved();
        int n0 = 0;
        int n3 = 0;
        do_reset();
        for (int c = 0; c < 14; c++) begin
            logic [3:0] exp_gnt;
            logic       exp_m;
            logic [1:0] exp_ch;
            exp_gnt = (c % 2 == 0) ? 4'b0001 : 4'b1000;
            exp_m   = (c == 12) || (c == 13);
            exp_ch  = (c == 12) ? 2'd0 : 2'd3;
            @(negedge clk);
            req    = '0;
            req[0] = (n0 < 7);
            req[3] = (n3 < 7);
            din[0] = pat_bit(n0);
            din[3] = pat_bit(n3);
            #1;
            total++;
            if (gnt !== exp_gnt)
                $display("FAIL inter_gnt%0d: gnt=%b want=%b", c, gnt, exp_gnt);
            else passed++;
            if (exp_gnt[0]) n0++; else n3++;
            @(posedge clk); #1;
            total++;
            if (match_vld !== exp_m || (exp_m && match_ch !== exp_ch))
                $display("FAIL inter_match%0d: match_vld=%b match_ch=%0d want %b/%0d",
                         c, match_vld, match_ch, exp_m, exp_ch);
            else passed++;
        end
        idle_check("inter");
    endtask

    task automatic test_async_reset();
        do_reset();
        for (int i = 0; i < 5; i++) send(0, pat_bit(i), 1'b0, "arst_pre");
        @(negedge clk);
        req = 4'b0001; din[0] = 1'b0;
        #2 rst = 1'b1;
        #1;
        total++;
        if (gnt !== 4'b0000 || match_vld !== 1'b0)
            $display("FAIL arst_now: gnt=%b match_vld=%b want 0000/0", gnt, match_vld);
        else passed++;
        @(negedge clk);
        rst = 1'b0;
        send(0, 1'b0, 1'b0, "arst_post");
        send(0, 1'b1, 1'b0, "arst_post");
        idle_check("arst");
    endtask

    task automatic test_counter();
        do_reset();
`ifdef SEQ_DET_CNT_EN
        // 7 bits for the first match, then every 2 bits another: 300 matches.
        @(negedge clk);
        req = 4'b0010;
        for (int i = 0; i < 605; i++) begin
            din[1] = pat_bit(i);
            @(negedge clk);
        end
        req = '0;
        cnt_sel = 2'd1;
        #1;
        total++;
        if (cnt_out !== 8'd255)
            $display("FAIL cnt_sat: cnt_out=%0d want 255", cnt_out);
        else passed++;
        cnt_sel = 2'd0;
        #1;
        total++;
        if (cnt_out !== 8'd0)
            $display("FAIL cnt_ch0: cnt_out=%0d want 0", cnt_out);
        else passed++;
`else
        for (int i = 0; i < 7; i++) send(1, pat_bit(i), i == 6, "nocnt");
        cnt_sel = 2'd1;
        #1;
        total++;
        if (cnt_out !== 8'h00)
            $display("FAIL cnt_tied: cnt_out=%0d want 0", cnt_out);
        else passed++;
`endif
    endtask

    initial begin
        test_reset();
        test_single();
        test_overlap();
        test_round_robin();
        test_clear();
        test_interleaved();
        test_async_reset();
        test_counter();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
